// File: rtl/chess_fb_pkg.sv
// Shared constants for the chess frame-buffer write path: requester ids,
// frame-buffer geometry and the write arbiter's state encoding.
package chess_fb_pkg;

  localparam int REQ_BOARD  = 0;
  localparam int REQ_PIECE  = 1;
  localparam int REQ_CURSOR = 2;

  localparam logic [31:0] FB_BASE   = 32'h0000_0000;
  localparam logic [31:0] FB_STRIDE = 32'd2560;  // 640 pixels x 4 bytes

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int BEAT_CNT_W = 8;

  function automatic logic [31:0] fb_pixel_addr(input logic [31:0] x,
                                                input logic [31:0] y);
    return FB_BASE + (y * FB_STRIDE) + (x << 2);
  endfunction

  // True when the beat being accepted now is the last one the grant may take.
  function automatic logic burst_done(input logic [BEAT_CNT_W-1:0] cnt,
                                      input int max_burst);
    return ({24'd0, cnt} + 32'd1) >= $unsigned(max_burst);
  endfunction

  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] cnt);
    return (cnt == {BEAT_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// last_i (wrapping), so the previous winner is lowest priority.
module rr_pick
  import chess_fb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GID_W-1:0]   last_i,
  output logic [GID_W-1:0]   win_o,
  output logic               any_o
);

  localparam int NSLOT = 1 << GID_W;

  logic [NSLOT-1:0] req_pad;
  logic [GID_W-1:0] cand;
  int               idx;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req_i;
  end

  // Walk candidates farthest-first so the nearest one after last_i wins.
  always_comb begin
    win_o = last_i;
    idx   = 0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(last_i) + k) % NUM_REQ;
      cand = idx[GID_W-1:0];
      if (req_pad[cand]) win_o = cand;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fb_wr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write master into the VGA frame
// buffer between pixel writers, with a per-grant burst budget.
module fb_wr_arbiter
  import chess_fb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ADDR_W-1:0]            avm_address,
  output logic [DATA_W-1:0]            avm_writedata,
  output logic [DATA_W/8-1:0]          avm_byteenable,
  output logic                         avm_write,
  input  logic                         avm_waitrequest,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int NSLOT = 1 << GID_W;

  logic [0:0]            state_q, state_d;
  logic [GID_W-1:0]      grant_id_q, grant_id_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;

  // Requester lanes padded to a power of two so grant_id always indexes in range.
  logic [NSLOT-1:0]  valid_slot;
  logic [NSLOT-1:0]  last_slot;
  logic [ADDR_W-1:0] addr_slot [NSLOT];
  logic [DATA_W-1:0] data_slot [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_REQ) begin : g_used
      assign valid_slot[g] = req_valid[g];
      assign last_slot[g]  = req_last[g];
      assign addr_slot[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign data_slot[g]  = req_data[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign valid_slot[g] = 1'b0;
      assign last_slot[g]  = 1'b0;
      assign addr_slot[g]  = '0;
      assign data_slot[g]  = '0;
    end
  end

  logic             pick_any;
  logic [GID_W-1:0] pick_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (grant_id_q),
    .win_o  (pick_id),
    .any_o  (pick_any)
  );

  logic in_grant;
  logic out_free;
  logic accept;
  logic release_grant;

  // The output register can take a beat when empty or when its beat leaves now.
  assign out_free      = !wr_q || !avm_waitrequest;
  assign in_grant      = (state_q == ST_GRANT);
  assign accept        = in_grant && out_free && valid_slot[grant_id_q];
  assign release_grant = accept &&
                         (last_slot[grant_id_q] || burst_done(beat_cnt_q, MAX_BURST));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = in_grant && out_free && (grant_id_q == GID_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      default: begin
        if (accept) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          if (release_grant) state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Avalon output stage: load on accept, drop write once drained, else hold.
  always_comb begin
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      wr_d   = 1'b1;
      addr_d = addr_slot[grant_id_q];
      data_d = data_slot[grant_id_q];
    end else if (out_free) begin
      wr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= GID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign avm_write      = wr_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = '1;
  assign grant_id       = grant_id_q;
  assign busy           = in_grant || wr_q;

endmodule
